// File: rtl/reg_file_pkg.sv
// Shared bus-width defines and register-file package.
// Optional write-first bypass: define REG_FILE_WB_BYPASS_EN.
`ifndef REG_FILE_DEFINES_SVH
`define REG_FILE_DEFINES_SVH
`define DATA_BUS_WIDTH     32
`define DATA_BUS           31:0
`define REG_ADDR_BUS_WIDTH 5
`define REG_ADDR_BUS       4:0
`define REG_NUM            32
`define ZERO_WORD          32'h0000_0000
`define REG_ZERO_ADDR      5'd0
`endif

package reg_file_pkg;

  localparam int DATA_W  = `DATA_BUS_WIDTH;
  localparam int ADDR_W  = `REG_ADDR_BUS_WIDTH;
  localparam int REG_CNT = `REG_NUM;

  localparam logic [DATA_W-1:0] ZERO_WORD = `ZERO_WORD;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = `REG_ZERO_ADDR;

  // Read-port mux selection
  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_BYP   = 2'd1,
    SEL_STORE = 2'd2
  } rd_sel_e;

  // A write-back that actually lands in the array
  function automatic logic wb_hit(
    input logic              rst,
    input logic              we,
    input logic [ADDR_W-1:0] wa
  );
    return rst && we && (wa != ZERO_ADDR);
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One register-file read port.
// Zero/enable mux, plus write-first bypass under REG_FILE_WB_BYPASS_EN.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int REG_NUM    = REG_CNT
) (
  input  logic                              rst,
  input  logic                              read_en,
  input  logic [ADDR_WIDTH-1:0]             read_addr,
  input  logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs,
  input  logic                              write_en,
  input  logic [ADDR_WIDTH-1:0]             write_addr,
  input  logic [DATA_WIDTH-1:0]             write_data,
  output logic [DATA_WIDTH-1:0]             read_data
);

  logic    idle;
  logic    hit;
  rd_sel_e sel;

  assign idle = !rst || !read_en
             || (read_addr == '0);

`ifdef REG_FILE_WB_BYPASS_EN
  assign hit = write_en
            && (write_addr == read_addr)
            && (write_addr != '0);
`else
  logic unused_wb;
  assign unused_wb = ^{write_en,
                       write_addr,
                       write_data};
  assign hit = 1'b0;
`endif

  // Select the source for this port
  always_comb begin
    sel = SEL_STORE;
    unique case (1'b1)
      idle:         sel = SEL_ZERO;
      (!idle && hit): sel = SEL_BYP;
      default:      sel = SEL_STORE;
    endcase
  end

  // Drive the port data from the selected source
  always_comb begin
    read_data = '0;
    unique case (sel)
      SEL_ZERO:  read_data = '0;
      SEL_BYP:   read_data = write_data;
      SEL_STORE: read_data = regs[read_addr];
      default:   read_data = '0;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// General-purpose register file, two reads and one write-back.
// Optional write-first bypass: define REG_FILE_WB_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int REG_NUM    = REG_CNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs;
  logic                               wr_go;

  assign wr_go = rst && write_en
              && (write_addr != '0);

  // Reset clears the array; r0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs <= '0;
    end else if (wr_go) begin
      regs[write_addr] <= write_data;
    end
  end

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_NUM    (REG_NUM)
  ) u_rp1 (
    .rst        (rst),
    .read_en    (read_en_1),
    .read_addr  (read_addr_1),
    .regs       (regs),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_data  (read_data_1)
  );

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_NUM    (REG_NUM)
  ) u_rp2 (
    .rst        (rst),
    .read_en    (read_en_2),
    .read_addr  (read_addr_2),
    .regs       (regs),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_data  (read_data_2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file.
// Expectations follow REG_FILE_WB_BYPASS_EN when it is defined.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        read_en_1;
  logic [4:0]  read_addr_1;
  logic [31:0] read_data_1;
  logic        read_en_2;
  logic [4:0]  read_addr_2;
  logic [31:0] read_data_2;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_en_1   (read_en_1),
    .read_addr_1 (read_addr_1),
    .read_data_1 (read_data_1),
    .read_en_2   (read_en_2),
    .read_addr_2 (read_addr_2),
    .read_data_2 (read_data_2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    step();
    write_en = 1'b0;
  endtask

  task automatic rd(
    input logic [4:0] a1,
    input logic [4:0] a2
  );
    read_en_1   = 1'b1;
    read_en_2   = 1'b1;
    read_addr_1 = a1;
    read_addr_2 = a2;
    #1;
  endtask

  logic [31:0] exp_v;

  initial begin
    rst         = 1'b0;
    write_en    = 1'b1;
    write_addr  = 5'd5;
    write_data  = 32'hDEADBEEF;
    read_en_1   = 1'b1;
    read_addr_1 = 5'd5;
    read_en_2   = 1'b1;
    read_addr_2 = 5'd5;

    // reset with a pending write
    step();
    chk("rst_rd1", read_data_1, 32'h0);
    chk("rst_rd2", read_data_2, 32'h0);
    step();
    rst      = 1'b1;
    write_en = 1'b0;
    #1;
    chk("post_rst_r5", read_data_1, 32'h0);

    // basic write then read
    wr(5'd3, 32'h12345678);
    rd(5'd3, 5'd3);
    chk("basic_p1", read_data_1, 32'h12345678);
    chk("basic_p2", read_data_2, 32'h12345678);

    // r0 hardwired zero, also during write
    write_en   = 1'b1;
    write_addr = 5'd0;
    write_data = 32'hFFFFFFFF;
    rd(5'd0, 5'd0);
    chk("r0_wcyc_p1", read_data_1, 32'h0);
    chk("r0_wcyc_p2", read_data_2, 32'h0);
    step();
    write_en = 1'b0;
    #1;
    chk("r0_after_p1", read_data_1, 32'h0);
    chk("r0_after_p2", read_data_2, 32'h0);

    // same-cycle write/read conflict
    wr(5'd7, 32'hAAAA0000);
    write_en   = 1'b1;
    write_addr = 5'd7;
    write_data = 32'h5555FFFF;
    rd(5'd7, 5'd3);
`ifdef REG_FILE_WB_BYPASS_EN
    exp_v = 32'h5555FFFF;
`else
    exp_v = 32'hAAAA0000;
`endif
    chk("conflict_p1", read_data_1, exp_v);
    chk("conflict_p2_other", read_data_2,
        32'h12345678);
    read_addr_2 = 5'd7;
    #1;
    chk("conflict_p2", read_data_2, exp_v);
    step();
    write_en = 1'b0;
    #1;
    chk("conflict_next_p1", read_data_1,
        32'h5555FFFF);
    chk("conflict_next_p2", read_data_2,
        32'h5555FFFF);

    // read enable gating
    wr(5'd9, 32'h0000BEEF);
    rd(5'd9, 5'd9);
    read_en_2 = 1'b0;
    #1;
    chk("ren_off", read_data_2, 32'h0);
    chk("ren_other_port", read_data_1,
        32'h0000BEEF);
    read_en_2 = 1'b1;
    #1;
    chk("ren_on", read_data_2, 32'h0000BEEF);

    // full sweep
    for (int i = 1; i < 32; i++)
      wr(5'(i), i * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      exp_v = i * 32'h01010101;
      chk($sformatf("sweep_p1_r%0d", i),
          read_data_1, exp_v);
      exp_v = (31 - i) * 32'h01010101;
      chk($sformatf("sweep_p2_r%0d", 31 - i),
          read_data_2, exp_v);
    end

    // reset in the middle of a write to r31
    rst        = 1'b0;
    write_en   = 1'b1;
    write_addr = 5'd31;
    write_data = 32'hCAFEF00D;
    rd(5'd31, 5'd31);
    chk("midrst_low_p1", read_data_1, 32'h0);
    chk("midrst_low_p2", read_data_2, 32'h0);
    step();
    rst      = 1'b1;
    write_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(i));
      chk($sformatf("midrst_p1_r%0d", i),
          read_data_1, 32'h0);
      chk($sformatf("midrst_p2_r%0d", i),
          read_data_2, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
